arm_fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the core; supplies `inst` and its PC to the core.
- Issues word reads to instruction memory over a request/grant + in-order response interface.
- Buffers returned words in a small prefetch FIFO.
- On a core redirect (branch or PC write), flushes the FIFO and squashes responses still in flight.

---
 rtl/arm_fetch_unit.sv | 92 +++++++++
 tb/tb_arm_fetch_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/arm_fetch_unit.sv
`timescale 1ns/1ps
// Instruction fetch stage: credit-limited word reads into a prefetch FIFO,
// with redirect-driven flush and squashing of responses still in flight.
module arm_fetch_unit #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          CNT_W      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } fetch_entry_t;

  fetch_entry_t [FIFO_DEPTH-1:0] fifo_q;
  logic [31:0]      fetch_pc, resp_pc, redir_pc;
  logic [CNT_W-1:0] outstanding, discard, count;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W:0]   credit_used;
  logic             xfer, beat, drop, push, pop;

  // Every FIFO slot is pre-booked by either a queued word, a live request or a squashed one.
  assign credit_used = {1'b0, count} + {1'b0, outstanding} + {1'b0, discard};
  assign imem_req    = !rst && !halt && !redirect_valid &&
                       (credit_used < (CNT_W+1)'(FIFO_DEPTH));
  assign imem_addr   = fetch_pc;
  assign redir_pc    = redirect_addr & ~32'h3;

  assign xfer = imem_req && imem_gnt;
  // A beat with nothing owed is a protocol error and is ignored.
  assign beat = imem_rvalid && ((outstanding != '0) || (discard != '0));
  assign drop = beat && (discard != '0);
  assign push = beat && (discard == '0) && !redirect_valid;
  assign pop  = inst_valid && inst_ready && !redirect_valid;

  assign inst_valid = (count != '0);
  assign inst       = fifo_q[rd_ptr].data;
  assign inst_pc    = fifo_q[rd_ptr].pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_q      <= '0;
    end else if (redirect_valid) begin
      fetch_pc    <= redir_pc;
      resp_pc     <= redir_pc;
      outstanding <= '0;
      // Everything in flight becomes stale; a same-cycle beat is already dropped.
      discard     <= discard + outstanding - CNT_W'(beat);
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      if (xfer) fetch_pc <= fetch_pc + 32'd4;
      outstanding <= outstanding + CNT_W'(xfer) - CNT_W'(push);
      if (drop) discard <= discard - CNT_W'(1);
      if (push) begin
        fifo_q[wr_ptr] <= '{pc: resp_pc, data: imem_rdata};
        wr_ptr         <= wr_ptr + PTR_W'(1);
        resp_pc        <= resp_pc + 32'd4;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && count == CNT_W'(FIFO_DEPTH)));

endmodule

// File: tb/tb_arm_fetch_unit.sv
`timescale 1ns/1ps
// Scoreboard bench for arm_fetch_unit: a latency-programmable memory model
// pushes expected {pc, data} on accepted beats, a monitor checks every pop.
module tb_arm_fetch_unit;
  logic        clk, rst, halt, redirect_valid, imem_req, imem_gnt;
  logic        imem_rvalid, inst_valid, inst_ready;
  logic [31:0] redirect_addr, imem_addr, imem_rdata, inst, inst_pc;

  arm_fetch_unit #(.FIFO_DEPTH(4), .RESET_PC(32'h0), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .halt(halt),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_ready(inst_ready)
  );

  typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;
  typedef struct { logic [31:0] addr; int due; int ep; } pend_t;

  exp_t        exp_q[$];
  pend_t       pend[$];
  logic [31:0] issued[$];
  logic [31:0] popped[$];
  int          n_chk = 0, n_fail = 0, pop_cnt = 0, lat = 1, epoch = 0, cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] q_at(logic [31:0] q[$], int i);
    return (q.size() > i) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  // Memory: samples the handshake just before each edge, drives rvalid just after.
  initial begin
    logic [31:0] cur_addr, exp_next;
    int          cur_ep;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    cur_addr    = '0;
    cur_ep      = 0;
    exp_next    = '0;
    forever begin
      @(negedge clk); #3;
      if (rst) begin
        pend.delete();
        exp_q.delete();
        exp_next = 32'h0;
        epoch++;
      end else begin
        if (imem_rvalid) begin
          chk("rvalid_owed", 32'(dut.outstanding + dut.discard != 0), 32'd1);
          if (!redirect_valid && cur_ep == epoch)
            exp_q.push_back('{pc: cur_addr, data: mem_word(cur_addr)});
        end
        if (redirect_valid) begin
          epoch++;
          exp_q.delete();
          exp_next = {redirect_addr[31:2], 2'b00};
        end
        if (imem_req && imem_gnt) begin
          chk("imem_addr_seq", imem_addr, exp_next);
          exp_next = exp_next + 32'd4;
          issued.push_back(imem_addr);
          pend.push_back('{addr: imem_addr, due: cyc + lat, ep: epoch});
        end
      end
      @(posedge clk); #1;
      cyc++;
      if (!rst && pend.size() != 0 && pend[0].due <= cyc) begin
        imem_rvalid = 1'b1;
        cur_addr    = pend[0].addr;
        cur_ep      = pend[0].ep;
        imem_rdata  = mem_word(cur_addr);
        void'(pend.pop_front());
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
      end
    end
  end

  // Monitor: every delivered instruction must match the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #4;
      if (!rst && inst_valid && inst_ready && !redirect_valid) begin
        pop_cnt++;
        popped.push_back(inst_pc);
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_inst: got pc %h, nothing expected", inst_pc);
        end else begin
          e = exp_q.pop_front();
          chk("inst_pc", inst_pc, e.pc);
          chk("inst", inst, e.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic do_reset();
    rst = 1'b1; halt = 1'b0; redirect_valid = 1'b0;
    tick(2);
    issued.delete();
    popped.delete();
    rst = 1'b0;
  endtask

  task automatic drain(string name);
    halt = 1'b1;
    tick(10);
    chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_empty"}, 32'(inst_valid), 32'd0);
  endtask

  initial begin
    int p0, n0;
    rst = 1'b1; halt = 1'b0; redirect_valid = 1'b0; redirect_addr = '0;
    imem_gnt = 1'b0; inst_ready = 1'b0;
    tick(2); #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);

    // 1: streaming, with an initial two-cycle grant stall
    do_reset(); lat = 1; inst_ready = 1'b1; imem_gnt = 1'b0; #1;
    chk("t1_req", 32'(imem_req), 32'd1);
    chk("t1_addr0", imem_addr, 32'h0);
    tick(1); #1;
    chk("t1_hold_addr", imem_addr, 32'h0);
    chk("t1_no_grant", 32'(issued.size()), 32'd0);
    imem_gnt = 1'b1;
    tick(4); p0 = pop_cnt;
    tick(8);
    chk("t1_rate", 32'(pop_cnt - p0), 32'd8);
    chk("t1_a0", q_at(issued, 0), 32'h0);
    chk("t1_a1", q_at(issued, 1), 32'h4);
    chk("t1_a2", q_at(issued, 2), 32'h8);
    chk("t1_a3", q_at(issued, 3), 32'hC);
    drain("t1");

    // 2: core stalled, credit limit fills the FIFO exactly
    do_reset(); lat = 1; inst_ready = 1'b0; imem_gnt = 1'b1;
    tick(8); #1;
    chk("t2_issued", 32'(issued.size()), 32'd4);
    chk("t2_req_off", 32'(imem_req), 32'd0);
    chk("t2_count", 32'(dut.count), 32'd4);
    chk("t2_head_pc", inst_pc, 32'h0);
    chk("t2_head", inst, mem_word(32'h0));
    inst_ready = 1'b1;
    tick(4);
    chk("t2_resume", q_at(issued, 4), 32'h10);
    chk("t2_pop3", q_at(popped, 3), 32'hC);
    // reset in the middle of traffic
    do_reset(); #1;
    chk("midrst_valid", 32'(inst_valid), 32'd0);
    chk("midrst_addr", imem_addr, 32'h0);
    chk("midrst_out", 32'(dut.outstanding), 32'd0);

    // 3: redirect with two requests in flight
    lat = 3; inst_ready = 1'b1; imem_gnt = 1'b1;
    tick(2);
    redirect_valid = 1'b1; redirect_addr = 32'h1002; #1;
    chk("t3_req_in_redir", 32'(imem_req), 32'd0);
    tick(1);
    redirect_valid = 1'b0; #1;
    chk("t3_discard", 32'(dut.discard), 32'd2);
    chk("t3_addr", imem_addr, 32'h1000);
    tick(10);
    chk("t3_issue", q_at(issued, 2), 32'h1000);
    chk("t3_first_pc", q_at(popped, 0), 32'h1000);
    drain("t3");

    // 4: redirect coinciding with a response and a pop
    do_reset(); lat = 2; inst_ready = 1'b1; imem_gnt = 1'b1;
    tick(3); #1;
    chk("t4_pre_valid", 32'(inst_valid), 32'd1);
    chk("t4_pre_rvalid", 32'(imem_rvalid), 32'd1);
    chk("t4_pre_out", 32'(dut.outstanding), 32'd2);
    redirect_valid = 1'b1; redirect_addr = 32'h0000_0200;
    tick(1);
    redirect_valid = 1'b0; #1;
    chk("t4_flushed", 32'(inst_valid), 32'd0);
    chk("t4_discard", 32'(dut.discard), 32'd1);
    chk("t4_out", 32'(dut.outstanding), 32'd0);
    tick(10);
    chk("t4_first_pc", q_at(popped, 0), 32'h200);
    drain("t4");

    // 5: halt with two requests outstanding
    do_reset(); lat = 3; inst_ready = 1'b1; imem_gnt = 1'b1;
    tick(2);
    halt = 1'b1; #1;
    chk("t5_req_off", 32'(imem_req), 32'd0);
    tick(6);
    chk("t5_issued", 32'(issued.size()), 32'd2);
    chk("t5_pop0", q_at(popped, 0), 32'h0);
    chk("t5_pop1", q_at(popped, 1), 32'h4);
    halt = 1'b0;
    tick(2);
    chk("t5_resume", q_at(issued, 2), 32'h8);
    drain("t5");

    // 6: redirect while halted, then wrap past the top of memory
    lat = 1; redirect_valid = 1'b1; redirect_addr = 32'hFFFF_FFF8;
    tick(1);
    redirect_valid = 1'b0;
    tick(2); #1;
    chk("t6_halted", 32'(imem_req), 32'd0);
    chk("t6_addr", imem_addr, 32'hFFFF_FFF8);
    n0 = issued.size();
    halt = 1'b0;
    tick(3);
    chk("t6_a0", q_at(issued, n0), 32'hFFFF_FFF8);
    chk("t6_a1", q_at(issued, n0 + 1), 32'hFFFF_FFFC);
    chk("t6_a2", q_at(issued, n0 + 2), 32'h0000_0000);
    drain("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
